uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer directly downstream of `uart_rx`. It captures each byte that `uart_rx` presents on `data_out` when `done` rises, and stores it in a first-word-fall-through FIFO for the consumer (CPU/bus side). It also provides occupancy flags, an almost-full threshold for RTS-style flow control, and sticky overrun reporting with a saturating count of dropped bytes.

## Interface
Parameters:
- `DATA_W`, 8, byte width; matches `uart_rx` `data_out`
- `ADDR_W`, 4, pointer width; depth = 2**ADDR_W (16)
- `AF_LEVEL`, 12, `almost_full` asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W

Ports:
- `rx_clk`  in  1  single clock, rising edge; same clock as `uart_rx`
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  block enable; when low, writes and reads are ignored and state is held
- `wr_data`  in  DATA_W  byte from `uart_rx` `data_out`
- `wr_done`  in  1  `uart_rx` `done`; level or pulse, rising edge is the write event
- `rd_en`  in  1  pop head entry (consumer acknowledge)
- `ovr_clr`  in  1  clears `overrun` and `drop_cnt`
- `rd_data`  out  DATA_W  head entry (FWFT); 0 when empty
- `empty`  out  1  count == 0
- `full`  out  1  count == 2**ADDR_W
- `almost_full`  out  1  count >= AF_LEVEL
- `count`  out  ADDR_W+1  current occupancy, 0..2**ADDR_W
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full
- `drop_cnt`  out  8  saturating count of dropped bytes (stops at 255)

## Operation
- Edge detect: `done_q` <= `wr_done` every cycle, regardless of `en`. Write event `we` = `en & wr_done & ~done_q`. A `done` held high for many cycles therefore produces exactly one write. A `done` already high when `en` rises produces no write.
- Read event: `re` = `en & rd_en & ~empty`. `rd_en` while empty is ignored, with no side effects.
- Storage: `mem[2**ADDR_W]`, `wr_ptr` and `rd_ptr` are ADDR_W bits and wrap modulo depth naturally. `count` is held in a register.
- Per cycle, decided by `we`, `re`, `full`:
  - we only, not full: store `wr_data` at `wr_ptr`; `wr_ptr`+1; `count`+1.
  - we only, full: byte dropped; `overrun` <= 1; `drop_cnt` <= min(`drop_cnt`+1, 255). Pointers and `count` unchanged.
  - re only: `rd_ptr`+1; `count`-1.
  - we and re: both happen; `count` unchanged. This includes the full case, where the read frees the slot and the write is accepted with no overrun. It also includes count==1.
  - neither: hold.
- `rd_data` = `mem[rd_ptr]` when `!empty`, else 0. This is combinational from registered state.
- `ovr_clr`: `overrun` <= 0 and `drop_cnt` <= 0. If a drop occurs in the same cycle, the drop wins: `overrun`=1 and `drop_cnt`=1.
- `ovr_clr` acts regardless of `en`.
- No state machine beyond the pointer/count datapath. Flags are combinational decodes of `count`.

## Timing
- Reset (async assert, released on `rx_clk`) sets:
  - pointers = 0, `count` = 0, `done_q` = 0, `overrun` = 0, `drop_cnt` = 0
  - therefore `empty`=1, `full`=0, `almost_full`=0, `rd_data`=0
  - memory contents are not reset and are don't-care
- Reset mid-operation discards all stored bytes immediately.
- Write latency: `wr_done` is first sampled high at edge N. The byte is visible on `rd_data` and `empty` falls after edge N, so it is readable in cycle N+1.
- Read: with `rd_en` high at edge N, `rd_data` shows the next entry (or 0 and `empty`=1) after edge N.
- `count`, `full`, `almost_full` and `overrun` all update on the same edge as the causing event.
- Back-to-back `uart_rx` bytes (at least 8 clocks per bit) never stress throughput. One write per cycle is supported.

## Test plan
- Reset then single byte: `wr_data`=8'hA5, pulse `wr_done` -> next cycle `rd_data`=A5, `empty`=0, `count`=1; `rd_en` 1 cycle -> `empty`=1, `rd_data`=0.
- Level `done`: `wr_done` held high 20 cycles with `wr_data`=8'h3C -> `count`=1 exactly; drop low then high again -> `count`=2.
- Fill and wrap: write 0x00..0x0F -> `full`=1, `almost_full` asserted from the 12th write; read 4, write 0x10..0x13, then read all -> order 0x04..0x13, pointers wrapped, `empty`=1.
- Overrun: fill 16, write 3 more -> `overrun`=1, `drop_cnt`=3, contents unchanged; `ovr_clr` -> both 0. Then with `ovr_clr` and a full-drop in the same cycle -> `overrun`=1, `drop_cnt`=1.
- Simultaneous read/write when full: `we` and `rd_en` in the same cycle -> `count` stays 16, no overrun, new byte appears at the tail. `rd_en` while empty -> no change.
- Enable and reset: `en`=0 with `wr_done` pulse -> no write. `wr_done` held high across `en` rising -> no write. Assert `rst` asynchronously with `count`=5 -> outputs immediately at their reset values.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_fifo                                                      |
// | Brief  : FWFT receive FIFO behind uart_rx with flags and overrun counting  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              rx_clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    input  logic              rd_en,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic [7:0]        drop_cnt
);

    localparam int            c_DEPTH_I = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(c_DEPTH_I);
    localparam logic [ADDR_W:0] c_AF    = (ADDR_W + 1)'(AF_LEVEL);

    logic [DATA_W-1:0] r_mem [c_DEPTH_I];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_done_q;
    logic              r_overrun;
    logic [7:0]        r_drop_cnt;

    logic w_we;
    logic w_re;
    logic w_push;
    logic w_drop;

    assign empty       = (r_count == '0);
    assign full        = (r_count == c_DEPTH);
    assign almost_full = (r_count >= c_AF);
    assign count       = r_count;
    assign overrun     = r_overrun;
    assign drop_cnt    = r_drop_cnt;
    assign rd_data     = empty ? '0 : r_mem[r_rd_ptr];

    assign w_we   = en & wr_done & ~r_done_q;
    assign w_re   = en & rd_en & ~empty;
    // A simultaneous read frees the head slot, so a write into a full FIFO is accepted.
    assign w_push = w_we & (~full | w_re);
    assign w_drop = w_we & full & ~w_re;

    always_ff @(posedge rx_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_done_q   <= 1'b0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_done_q <= wr_done;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_re})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear restarts the count at one.
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (ovr_clr) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (ovr_clr) begin
                r_overrun  <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Bench for uart_rx_fifo: directed vector table, corner sequences and random
// traffic compared against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overrun;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] q[$];
    logic       m_done_q;
    logic       m_ovr;
    int         m_drops;

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .rx_clk(clk), .rst(rst), .en(en), .wr_data(wr_data), .wr_done(wr_done),
        .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .empty(empty),
        .full(full), .almost_full(almost_full), .count(count),
        .overrun(overrun), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done_q = 1'b0;
        m_ovr    = 1'b0;
        m_drops  = 0;
    endtask

    task automatic model_edge();
        bit we, re, drop;
        we   = en && wr_done && !m_done_q;
        re   = en && rd_en && (q.size() > 0);
        drop = we && !re && (q.size() == 16);
        if (re) void'(q.pop_front());
        if (we && !drop) q.push_back(wr_data);
        if (ovr_clr) begin
            m_ovr   = 1'b0;
            m_drops = 0;
        end
        if (drop) begin
            m_ovr   = 1'b1;
            m_drops = (m_drops + 1 > 255) ? 255 : m_drops + 1;
        end
        m_done_q = wr_done;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".rd_data"}, 32'(rd_data), (n > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 16));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 12));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    endtask

    // One clock: inputs already set; model follows the edge; outputs sampled 1ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input logic e, input logic d, input logic [7:0] dat,
                          input logic r, input logic c);
        en = e; wr_done = d; wr_data = dat; rd_en = r; ovr_clr = c;
    endtask

    task automatic write_byte(input logic [7:0] b, input string tag);
        set_in(1, 1, b, 0, 0); step(tag);
        set_in(1, 0, b, 0, 0); step(tag);
    endtask

    task automatic read_byte(input string tag);
        set_in(1, 0, 8'h00, 1, 0); step(tag);
    endtask

    typedef struct {
        logic       en;
        logic       done;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        logic [4:0] exp_count;
        logic [7:0] exp_rd;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic d, logic [7:0] dat, logic r, logic c,
                                logic [4:0] ec, logic [7:0] er, logic ee);
        vec_t v;
        v.en = e; v.done = d; v.data = dat; v.rd = r; v.clr = c;
        v.exp_count = ec; v.exp_rd = er; v.exp_empty = ee;
        return v;
    endfunction

    initial begin
        set_in(0, 0, 8'h00, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // directed table: single byte, empty read, level done, enable gating
        vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 5'd1, 8'hA5, 0));
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 5'd0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 5'd0, 8'h00, 1));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 5'd1, 8'h3C, 0));
        vecs.push_back(mk(1, 0, 8'h3C, 0, 0, 5'd1, 8'h3C, 0));
        vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 5'd2, 8'h3C, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 5'd2, 8'h3C, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 0, 5'd2, 8'h3C, 0));
        vecs.push_back(mk(1, 1, 8'h77, 0, 0, 5'd2, 8'h3C, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 5'd2, 8'h3C, 0));
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 5'd1, 8'h3C, 0));
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 5'd0, 8'h00, 1));
        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].done, vecs[i].data, vecs[i].rd, vecs[i].clr);
            step("vec");
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_empty));
        end

        // fill and wrap
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i), "fill");
            chk("fill.af", 32'(almost_full), 32'(i >= 11));
        end
        chk("fill.full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) read_byte("wrap_rd");
        for (int i = 0; i < 4; i++) write_byte(8'(8'h10 + i), "wrap_wr");
        for (int i = 0; i < 16; i++) begin
            chk("wrap.order", 32'(rd_data), 32'(8'h04 + i));
            read_byte("drain");
        end
        chk("wrap.empty", 32'(empty), 32'd1);

        // overrun, clear, and clear colliding with a drop
        for (int i = 0; i < 16; i++) write_byte(8'(8'h80 + i), "ovr_fill");
        for (int i = 0; i < 3; i++) write_byte(8'hEE, "ovr_drop");
        chk("ovr.flag", 32'(overrun), 32'd1);
        chk("ovr.drop_cnt", 32'(drop_cnt), 32'd3);
        chk("ovr.head", 32'(rd_data), 32'h80);
        set_in(1, 0, 8'h00, 0, 1); step("ovr_clr");
        chk("clr.flag", 32'(overrun), 32'd0);
        chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);
        write_byte(8'hEE, "pre_clr");
        set_in(1, 1, 8'hDD, 0, 1); step("clr_drop");
        chk("clr_drop.flag", 32'(overrun), 32'd1);
        chk("clr_drop.drop_cnt", 32'(drop_cnt), 32'd1);
        set_in(1, 0, 8'h00, 0, 1); step("clr2");

        // simultaneous read and write while full
        set_in(1, 1, 8'h5A, 1, 0); step("rw_full");
        chk("rw_full.count", 32'(count), 32'd16);
        chk("rw_full.overrun", 32'(overrun), 32'd0);
        set_in(1, 0, 8'h00, 0, 0); step("rw_idle");
        for (int i = 0; i < 15; i++) read_byte("rw_drain");
        chk("rw_full.tail", 32'(rd_data), 32'h5A);
        read_byte("rw_last");

        // asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) write_byte(8'(8'h40 + i), "pre_rst");
        chk("pre_rst.count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_model("async_rst");
        chk("async_rst.empty", 32'(empty), 32'd1);
        #2 rst = 1'b0;

        // randomized traffic in low- and high-drain phases
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                set_in(($urandom_range(0, 9) != 0),
                       1'($urandom_range(0, 1)),
                       8'($urandom),
                       (ph[0] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0)),
                       ($urandom_range(0, 40) == 0));
                step("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
